// File: rtl/exec_ctrl.sv
// Execution controller: loads program words into instruction memory and
// gates CPU execution (run, single step, breakpoint, stop) with status.
module exec_ctrl #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [PC_WIDTH-1:0]    cmd_count,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_en,
    output logic                   cpu_rst,
    input  logic                   cpu_halted,
    input  logic [PC_WIDTH-1:0]    cpu_pc,
    input  logic                   bp_en,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    output logic [2:0]             state,
    output logic [1:0]             halt_cause,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_STOP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_HALT = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_STOP = 2'b11;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   load_addr_q, load_addr_d;
    logic [PC_WIDTH-1:0]   load_left_q, load_left_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic [1:0]            cause_q, cause_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  first_run_q, first_run_d;
    logic                  armed_q;
    logic                  cmd_acc;
    logic                  ld_acc;
    logic                  bp_hit;

    // armed_q holds off command acceptance until the second edge after reset release
    assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_HALT);
    assign cmd_acc    = cmd_valid && cmd_ready && armed_q;
    assign ld_ready   = (state_q == S_LOAD);
    assign ld_acc     = ld_valid && ld_ready;
    assign imem_we    = ld_acc;
    assign imem_addr  = load_addr_q;
    assign imem_wdata = ld_data;
    assign bp_hit     = bp_en && (cpu_pc == bp_addr) && !first_run_q;

    assign state       = state_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            load_addr_q <= '0;
            load_left_q <= '0;
            cycle_q     <= '0;
            cause_q     <= CAUSE_NONE;
            cpu_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            first_run_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            load_left_q <= load_left_d;
            cycle_q     <= cycle_d;
            cause_q     <= cause_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            first_run_q <= first_run_d;
            armed_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        load_left_d = load_left_q;
        cycle_d     = cycle_q;
        cause_d     = cause_q;
        cpu_rst_d   = 1'b0;
        done_d      = 1'b0;
        first_run_d = first_run_q;
        cpu_en      = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d     = S_RUN;
                            first_run_d = 1'b1;
                        end
                        OP_STEP: state_d = S_STEP;
                        OP_LOAD: begin
                            load_addr_d = '0;
                            load_left_d = cmd_count;
                            cycle_d     = '0;
                            cause_d     = CAUSE_NONE;
                            if (cmd_count == '0) begin
                                state_d   = S_IDLE;
                                cpu_rst_d = 1'b1;
                                done_d    = 1'b1;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (ld_acc) begin
                    load_addr_d = load_addr_q + PC_WIDTH'(1);
                    load_left_d = load_left_q - PC_WIDTH'(1);
                    if (load_left_q == PC_WIDTH'(1)) begin
                        state_d   = S_IDLE;
                        cpu_rst_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_en      = !cpu_halted && !bp_hit;
                first_run_d = 1'b0;
                // halt instruction outranks breakpoint, which outranks STOP
                if (cpu_halted) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_HALT;
                    done_d  = 1'b1;
                end else if (bp_hit) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BP;
                    done_d  = 1'b1;
                end else if (cmd_acc && (cmd_op == OP_STOP)) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_STOP;
                    done_d  = 1'b1;
                end
            end
            S_STEP: begin
                cpu_en  = !cpu_halted;
                state_d = S_HALT;
                cause_d = cpu_halted ? CAUSE_HALT : CAUSE_NONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (cpu_en && (cycle_q != '1)) begin
            cycle_d = cycle_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a tiny CPU model and an imem write scoreboard.
module tb_exec_ctrl;

    localparam int unsigned PW = 16;
    localparam int unsigned IW = 16;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [PW-1:0] cmd_count = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [IW-1:0] ld_data = '0;
    logic          imem_we;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          cpu_en;
    logic          cpu_rst;
    logic          cpu_halted;
    logic [PW-1:0] cpu_pc = '0;
    logic          bp_en = 1'b0;
    logic [PW-1:0] bp_addr = '0;
    logic [2:0]    state;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycle_count;
    logic          done;

    logic          halt_en = 1'b0;
    logic [PW-1:0] halt_pc = '0;
    int            en_cnt = 0;
    int            base;
    int            tests = 0;
    int            fails = 0;
    wr_t           exp_wr[$];
    logic [IW-1:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};

    exec_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst), .cpu_halted(cpu_halted), .cpu_pc(cpu_pc),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .state(state), .halt_cause(halt_cause), .cycle_count(cycle_count), .done(done)
    );

    always #5 CLK = ~CLK;

    // CPU stand-in: PC advances when enabled, halt instruction sits at halt_pc
    assign cpu_halted = halt_en && (cpu_pc == halt_pc);
    always @(posedge CLK) begin
        if (!RST_N || cpu_rst) cpu_pc <= '0;
        else if (cpu_en)       cpu_pc <= cpu_pc + 16'd1;
        if (cpu_en) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every imem write must match the oldest word the bench handed over
    always @(posedge CLK) begin
        if (imem_we) begin
            wr_t e;
            check("imem_spurious_we", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("imem_addr", 64'(imem_addr), 64'(e.addr));
                check("imem_wdata", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [PW-1:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_halt(input string tag);
        int n = 0;
        while (state != 3'd4 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 100), 64'd1);
    endtask

    initial begin
        // reset values
        tick();
        tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_halt_cause", 64'(halt_cause), 64'd0);

        // first command only taken on the second edge after release (LOAD N=0)
        #3;
        RST_N     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_count = '0;
        tick();
        check("arm_edge1_done", 64'(done), 64'd0);
        check("arm_edge1_cpu_rst", 64'(cpu_rst), 64'd0);
        tick();
        cmd_valid = 1'b0;
        check("load0_done", 64'(done), 64'd1);
        check("load0_cpu_rst", 64'(cpu_rst), 64'd1);
        check("load0_state", 64'(state), 64'd0);
        tick();
        check("load0_done_end", 64'(done), 64'd0);
        check("load0_cpu_rst_end", 64'(cpu_rst), 64'd0);

        // LOAD N=3 with gaps on ld_valid
        send(2'b11, 16'd3);
        check("load_state", 64'(state), 64'd1);
        check("load_ld_ready", 64'(ld_ready), 64'd1);
        check("load_cmd_ready", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b0;
            tick();
            check("load_gap_we", 64'(imem_we), 64'd0);
            exp_wr.push_back('{addr: 16'(i), data: words[i]});
            ld_valid = 1'b1;
            ld_data  = words[i];
            #1;
            check("load_we_comb", 64'(imem_we), 64'd1);
            tick();
        end
        ld_valid = 1'b0;
        check("load_end_state", 64'(state), 64'd0);
        check("load_end_done", 64'(done), 64'd1);
        check("load_end_cpu_rst", 64'(cpu_rst), 64'd1);
        tick();
        check("load_done_once", 64'(done), 64'd0);

        // RUN until halt instruction at pc 5
        halt_pc = 16'd5;
        halt_en = 1'b1;
        base    = en_cnt;
        send(2'b00, '0);
        run_until_halt("run_halt");
        check("run_halt_en_edges", 64'(en_cnt - base), 64'd5);
        check("run_halt_cause", 64'(halt_cause), 64'd1);
        check("run_halt_cycles", 64'(cycle_count), 64'd5);
        check("run_halt_done", 64'(done), 64'd1);
        check("run_halt_cpu_en", 64'(cpu_en), 64'd0);
        tick();
        check("run_halt_done_end", 64'(done), 64'd0);

        // breakpoint at 3, then resume past it
        halt_en = 1'b0;
        send(2'b11, '0);
        tick();
        bp_en   = 1'b1;
        bp_addr = 16'd3;
        send(2'b00, '0);
        run_until_halt("bp");
        check("bp_pc", 64'(cpu_pc), 64'd3);
        check("bp_cause", 64'(halt_cause), 64'd2);
        check("bp_cycles", 64'(cycle_count), 64'd3);
        send(2'b00, '0);
        check("bp_resume_en", 64'(cpu_en), 64'd1);
        tick();
        check("bp_no_rehalt", 64'(state), 64'd2);
        check("bp_resume_pc", 64'(cpu_pc), 64'd4);
        send(2'b10, '0);
        check("stop_state", 64'(state), 64'd4);
        check("stop_cause", 64'(halt_cause), 64'd3);
        check("stop_cycles", 64'(cycle_count), 64'd5);

        // STEP twice, the first onto a breakpoint address that must be ignored
        bp_addr = 16'd5;
        base    = en_cnt;
        send(2'b01, '0);
        check("step1_state", 64'(state), 64'd3);
        check("step1_cmd_ready", 64'(cmd_ready), 64'd0);
        check("step1_cpu_en", 64'(cpu_en), 64'd1);
        tick();
        bp_en = 1'b0;
        check("step1_halt", 64'(state), 64'd4);
        check("step1_cause", 64'(halt_cause), 64'd0);
        check("step1_done", 64'(done), 64'd1);
        check("step1_en_edges", 64'(en_cnt - base), 64'd1);
        send(2'b01, '0);
        check("step2_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("step2_cycles", 64'(cycle_count), 64'd7);
        check("step2_en_edges", 64'(en_cnt - base), 64'd2);
        check("step2_pc", 64'(cpu_pc), 64'd7);

        // STEP onto a halt instruction
        halt_pc = 16'd7;
        halt_en = 1'b1;
        send(2'b01, '0);
        check("step_halt_cpu_en", 64'(cpu_en), 64'd0);
        tick();
        check("step_halt_cause", 64'(halt_cause), 64'd1);
        check("step_halt_cycles", 64'(cycle_count), 64'd7);

        // STOP accepted on the tenth executing edge; RUN/LOAD in RUN are dropped
        halt_en = 1'b0;
        send(2'b11, '0);
        tick();
        base = en_cnt;
        send(2'b00, '0);
        repeat (4) tick();
        send(2'b00, '0);
        check("run_cmd_dropped", 64'(state), 64'd2);
        send(2'b11, 16'd5);
        check("load_cmd_dropped", 64'(state), 64'd2);
        check("load_cmd_no_ld_ready", 64'(ld_ready), 64'd0);
        repeat (3) tick();
        check("stop10_en_before", 64'(cpu_en), 64'd1);
        send(2'b10, '0);
        check("stop10_state", 64'(state), 64'd4);
        check("stop10_cause", 64'(halt_cause), 64'd3);
        check("stop10_cycles", 64'(cycle_count), 64'd10);
        check("stop10_en_edges", 64'(en_cnt - base), 64'd10);
        check("stop10_pc", 64'(cpu_pc), 64'd10);

        // reset in the middle of a LOAD N=4
        send(2'b11, 16'd4);
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back('{addr: 16'(i), data: 16'hA000 + 16'(i)});
            ld_valid = 1'b1;
            ld_data  = 16'hA000 + 16'(i);
            tick();
        end
        ld_data = 16'hA002;
        #2;
        RST_N = 1'b0;
        #1;
        check("ldrst_state", 64'(state), 64'd0);
        check("ldrst_imem_we", 64'(imem_we), 64'd0);
        check("ldrst_ld_ready", 64'(ld_ready), 64'd0);
        check("ldrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("ldrst_cpu_en", 64'(cpu_en), 64'd0);
        check("ldrst_done", 64'(done), 64'd0);
        check("ldrst_cpu_rst", 64'(cpu_rst), 64'd0);
        tick();
        tick();
        ld_valid = 1'b0;
        RST_N    = 1'b1;
        tick();
        check("ldrst_no_done", 64'(done), 64'd0);
        tick();
        send(2'b11, '0);
        check("final_load0_done", 64'(done), 64'd1);
        check("final_load0_cpu_rst", 64'(cpu_rst), 64'd1);
        tick();
        check("writes_all_seen", 64'(exp_wr.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, instruction-memory address and PC width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, instruction word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, executed-cycle counter width.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; accepted on an edge with both high.
REQ-007 cmd_op  in  2  00 RUN, 01 STEP, 10 STOP, 11 LOAD.
REQ-008 cmd_count  in  PC_WIDTH  word count for LOAD; ignored otherwise.
REQ-009 ld_valid/ld_ready/ld_data  in/out/in  1/1/INSTR_WIDTH  program-word stream.
REQ-010 imem_we, imem_addr, imem_wdata  out  1, PC_WIDTH, INSTR_WIDTH  instruction-memory write port.
REQ-011 cpu_en  out  1  CPU advances PC and writes registers on an edge only when high.
REQ-012 cpu_rst  out  1  one-cycle pulse clearing CPU PC to 0.
REQ-013 cpu_halted  in  1  current instruction is a halt (combinational from CPU).
REQ-014 cpu_pc  in  PC_WIDTH  current CPU PC.
REQ-015 bp_en, bp_addr  in  1, PC_WIDTH  breakpoint enable and address.
REQ-016 state  out  3  IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
REQ-017 halt_cause  out  2  00 none, 01 halt instr, 10 breakpoint, 11 STOP.
REQ-018 cycle_count  out  CNT_WIDTH  edges on which cpu_en was high since last LOAD.
REQ-019 done  out  1  one-cycle pulse on LOAD completion or entry to HALT.

Function
REQ-020 cmd_ready SHALL be 1 in IDLE, HALT, RUN; 0 in LOAD, STEP.
REQ-021 IDLE/HALT: RUN -> RUN; STEP -> STEP; LOAD -> LOAD (N>0) with load address cleared to 0; STOP accepted, no effect.
REQ-022 LOAD with cmd_count=0 SHALL stay IDLE, pulse cpu_rst and done next cycle, no writes.
REQ-023 In LOAD ld_ready SHALL be 1; each ld handshake SHALL drive imem_we=1, imem_addr=load address, imem_wdata=ld_data combinationally that cycle, then increment address.
REQ-024 Accepting the N-th word SHALL transition to IDLE; cpu_rst and done pulse the following cycle; cycle_count and halt_cause cleared at LOAD acceptance.
REQ-025 imem_we SHALL never be high outside LOAD; cpu_en SHALL be 0 in IDLE, LOAD, HALT.
REQ-026 RUN: cpu_en = !cpu_halted && !bp_hit, bp_hit = bp_en && cpu_pc==bp_addr && not first RUN cycle.
REQ-027 RUN SHALL go to HALT on the edge where cpu_halted (cause 01) or bp_hit (cause 10); halt instr wins if both.
REQ-028 STOP accepted in RUN SHALL go to HALT, cause 11; cpu_en stays as in REQ-026 on that edge (that instruction executes); RUN/STEP/LOAD in RUN are accepted and discarded.
REQ-029 STEP: cpu_en = !cpu_halted for exactly one cycle, breakpoint ignored, then HALT; cause 01 if cpu_halted, else 00.
REQ-030 done SHALL pulse one cycle after every entry to HALT.
REQ-031 cycle_count SHALL increment on every edge with cpu_en=1 and saturate at all-ones.

Reset
REQ-032 RST_N low SHALL immediately force state=IDLE, load address 0, cycle_count 0, halt_cause 00, cpu_en/imem_we/cpu_rst/done/ld_ready 0, cmd_ready 1.
REQ-033 Reset during LOAD SHALL abandon the load; words already written are not rewritten; no done pulse.
REQ-034 After RST_N deasserts, first command SHALL be accepted on the second rising edge.

Verification
REQ-035 LOAD N=3, words 0x1111,0x2222,0x3333 with ld_valid gaps -> writes at addr 0,1,2 only on handshakes; IDLE; cpu_rst and done pulse once.
REQ-036 RUN, cpu_halted rises when cpu_pc=5 -> cpu_en high 5 cycles, HALT, cause 01, cycle_count=5, done pulse.
REQ-037 bp_en=1, bp_addr=3, RUN from pc 0 -> HALT at pc 3, cause 10; RUN again from pc 3 -> does not re-halt at 3.
REQ-038 HALT, STEP x2 -> cpu_en high exactly one cycle each, cmd_ready 0 during STEP, cycle_count +2.
REQ-039 STOP in RUN at cycle 10 -> cpu_en high through accepting edge, HALT next, cause 11.
REQ-040 LOAD N=4, RST_N low after 2 words -> IDLE, outputs at reset values, no further imem_we; LOAD N=0 -> done+cpu_rst, no writes.
